// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes and FSM encodings for the multi-cycle mul/div sequencer.
package muldiv_sequencer_pkg;

    // Op codes as presented by the decoder for ALU_mult / ALU_div variants
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Shared iterative datapath: shift-add multiply / restoring divide on one
// 2*WIDTH shift register. Low half starts as multiplier / dividend, the
// operand register holds multiplicand / divisor (both as magnitudes).
module muldiv_iter_dp #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               fits;

    // One iteration of either algorithm; the remainder compare is WIDTH+1 bits wide
    always_comb begin
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        fits    = (shifted >= {1'b0, opnd_q});
        diff    = shifted[WIDTH-1:0] - opnd_q;
        acc_d   = acc_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
        end else if (step_i) begin
            if (is_div_i) begin
                if (fits) acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
                else      acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_i) opnd_q <= b_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mul/div sequencer; owns architectural HI/LO and raises a stall
// when EX tries to touch HI/LO or start a new op while one is in flight.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(STEPS + 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, res_neg_q, rem_neg_q, dz_q;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               busy_w, accept, sgn;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] acc, prod;

    assign busy_w = (state_q != ST_IDLE);
    assign accept = (state_q == ST_IDLE) && start && !flush;
    assign sgn    = md_is_signed(md_op_e'(op));
    assign a_mag  = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag  = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;

    muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .step_i   (state_q == ST_RUN),
        .is_div_i (is_div_q),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .acc_o    (acc)
    );

    // Next state and step counter; flush wins over everything including start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_RUN;
                cnt_d   = CW'(STEPS);
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // State, counter and the sign/zero flags captured at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                is_div_q  <= md_is_div(md_op_e'(op));
                res_neg_q <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                rem_neg_q <= sgn & md_is_div(md_op_e'(op)) & src_a[WIDTH-1];
                dz_q      <= md_is_div(md_op_e'(op)) & (src_b == '0);
            end
        end
    end

    // Sign fix-up and HI/LO write: op result in FIX, mthi/mtlo only when idle
    always_comb begin
        prod   = res_neg_q ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (state_q == ST_FIX && !flush) begin
            done_d = 1'b1;
            if (is_div_q) begin
                // divide-by-zero: quotient magnitude is all ones and remainder
                // is |a|, so only the quotient needs forcing
                lo_d = dz_q ? '1 : (res_neg_q ? -quo : quo);
                hi_d = rem_neg_q ? -rem : rem;
            end else begin
                {hi_d, lo_d} = prod;
            end
        end else if (!busy_w) begin
            if (mthi) hi_d = wdata;
            if (mtlo) lo_d = wdata;
        end
    end

    // Architectural HI/LO and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_w;
    assign done  = done_q;
    assign stall = busy_w & (start | mf_req | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, mthi, mtlo, mf_req, flush;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, stall;
    int          nchk = 0;
    int          npass = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32), .STEPS(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .mf_req (mf_req),
        .flush  (flush),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // wait for done (bounded), returns edges counted after the call
    task automatic wait_done(output int n, output int busy_drop);
        n = 0;
        busy_drop = 0;
        while (!done && n < 40) begin
            if (!busy) busy_drop++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, b,
                         input logic [31:0] ehi, elo);
        int n, bd;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_done(n, bd);
        check({tag, "_lat"}, n, 33);
        check({tag, "_busyheld"}, bd, 0);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_idle"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_donepulse"}, done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bd, seen;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; mf_req = 1'b0; flush = 1'b0;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // mthi + mtlo together while idle
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_hi", hi, 32'h1234);
        check("mt_lo", lo, 32'h1234);

        do_op("mult",   2'b00, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("multu",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("div",    2'b10, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu0",  2'b11, 32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF);
        do_op("divovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        do_op("divs0",  2'b10, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF);

        // mf_req five cycles into an op: stall until the done cycle
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) mf_req = 1'b1;
        #1;
        check("mf_stall", stall, 1);
        check("mf_hihold", hi, 32'hFFFFFFFB);
        check("mf_lohold", lo, 32'hFFFFFFFF);
        n = 0; bd = 0;
        while (!done && n < 40) begin
            if (!stall) bd++;
            @(posedge clk); #1;
            n++;
        end
        check("mf_stallheld", bd, 0);
        check("mf_done", done, 1);
        check("mf_stalldone", stall, 0);
        check("mf_hi", hi, 0);
        check("mf_lo", lo, 15);
        @(negedge clk) mf_req = 1'b0;

        // flush at cycle 10 of a DIV
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        check("flush_nodone", seen, 0);
        check("flush_hi", hi, 0);
        check("flush_lo", lo, 15);

        // flush beats a same-cycle start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flstart_busy", busy, 0);

        // start with mtlo in the same idle cycle: write lands, FIX overwrites
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd3; mtlo = 1'b1; wdata = 32'hAAAA;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        check("stmt_lo", lo, 32'hAAAA);
        check("stmt_busy", busy, 1);
        wait_done(n, bd);
        check("stmt_lat", n, 33);
        check("stmt_rhi", hi, 0);
        check("stmt_rlo", lo, 6);

        // reset mid-operation
        @(negedge clk);
        mthi = 1'b1; wdata = 32'hBEEF;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("pre_rst_hi", hi, 32'hBEEF);
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        mf_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mrst_hi", hi, 0);
        check("mrst_lo", lo, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_stall", stall, 0);
        mf_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        do_op("multmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for multiply/divide and owner of the architectural HI/LO registers.
- Replaces the single-cycle combinational mult/div path in the execute-stage ALU.
- Accepts one operation at a time from EX and iterates a shared 32-step shift/add-subtract datapath.
- Raises a stall to the hazard unit when a HI/LO access or a new start collides with an in-flight operation.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- STEPS, 32, iterations per operation; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a mul/div this cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- mthi  in  1  write HI from wdata
- mtlo  in  1  write LO from wdata
- wdata  in  WIDTH  mthi/mtlo data
- mf_req  in  1  EX/MEM reads HI or LO this cycle
- flush  in  1  abort any in-flight operation
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, HI/LO just updated by an operation
- stall  out  1  freeze IF/ID/EX this cycle

Behaviour:
- Reset (rst_n low, asynchronous): hi=0, lo=0, busy=0, done=0, stall=0, FSM=IDLE, step counter=0.
- FSM states:
  - IDLE: start=1 latches operands and op. MULT/DIV store magnitudes plus result-sign and remainder-sign flags; unsigned ops store raw values. Counter is loaded with STEPS. Next state RUN.
  - RUN: one iteration per cycle. Multiply: shift-add into a 2*WIDTH accumulator. Divide: restoring shift-subtract. Counter decrements; at 0 the next state is FIX.
  - FIX: apply two's-complement negation per sign flags, write hi/lo, done=1. Next state IDLE.
- Latency: start sampled at edge E0; busy=1 from E0 through E33; hi/lo update and done=1 at edge E33, i.e. 33 cycles after start.
- busy is 1 in RUN and FIX. done is 1 only in the cycle after the FIX edge.
- Results:
  - MULT/MULTU: {hi,lo} = full 64-bit product.
  - DIV/DIVU: lo = quotient (truncated toward zero), hi = remainder, which carries the sign of the dividend.
  - Division by zero: lo=32'hFFFFFFFF, hi=src_a. done timing is unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Magnitude arithmetic is 33-bit internally, so no trap.
- stall = busy & (start | mf_req | mthi | mtlo). A start, HI/LO read or HI/LO write never proceeds mid-operation. Because of stall, start asserted while busy is ignored.
- mthi/mtlo when not busy: the register updates at the next edge. mthi and mtlo may both be 1 in the same cycle.
- start and mthi/mtlo in the same idle cycle: the operation starts and the mt write also lands. The operation's FIX overwrites both registers.
- flush: at the next edge FSM goes to IDLE and busy=0. hi/lo are unchanged and no done is produced. flush has priority over start in the same cycle; the start is dropped.
- rst_n asserted mid-operation: immediate return to reset values.
- Mid-operation, hi/lo hold their previous architectural values.

Decomposition:
- Shared header: MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op codes and FSM state encodings (IDLE/RUN/FIX), alongside the existing ALU_* codes.
- The decoder maps ALU_mult/ALU_div onto these codes.
- One natural sub-module: muldiv_iter_dp. It holds the accumulator/remainder shift register and the adder/subtractor, driven by load/step/is_div controls. The FSM, counter, sign fix, HI/LO and stall logic stay in muldiv_sequencer.

Test Plan:
- MULT src_a=-3, src_b=7 -> busy 33 cycles, then done; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mf_req asserted 5 cycles after start -> stall=1 until the done cycle, stall=0 in the done cycle. mthi 0x1234 while idle -> hi=0x1234 next cycle.
- flush at cycle 10 of a DIV -> busy=0 next cycle, no done, hi/lo keep their old values. rst_n low at cycle 20 -> all outputs 0 immediately.
